// File: rtl/proc_pkg.sv
// Shared types for the multicycle processor control unit: FSM state codes, opcodes, ALU selects, control bundle.
// Latency: n/a (types only). Backpressure: none.
package proc_pkg;

  localparam int IR_W    = 16;
  localparam int ADDR_W  = 8;
  localparam int REG_AW  = 4;
  localparam int ALU_SW  = 3;
  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_LOAD_A = 4'd4,
    ST_LOAD_B = 4'd5,
    ST_STORE  = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
    ST_HALT   = 4'd9,
    ST_JUMP   = 4'd10
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;
  localparam logic [3:0] OP_JMP   = 4'd6;

  localparam logic [ALU_SW-1:0] ALU_PASS = 3'd0;
  localparam logic [ALU_SW-1:0] ALU_ADD  = 3'd1;
  localparam logic [ALU_SW-1:0] ALU_SUB  = 3'd2;

  // Every datapath control driven by the FSM, bundled so the decoder has a single output.
  typedef struct packed {
    logic              pc_clr;
    logic              pc_up;
    logic              ir_ld;
    logic              pc_ld;
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] d_addr;
    logic              d_wr;
    logic              rf_s;
    logic [REG_AW-1:0] rf_w_addr;
    logic              rf_w_en;
    logic [REG_AW-1:0] rf_ra_addr;
    logic [REG_AW-1:0] rf_rb_addr;
    logic [ALU_SW-1:0] alu_s0;
  } ctrl_t;

  function automatic logic [3:0] opcode_of(input logic [IR_W-1:0] ir);
    return ir[15:12];
  endfunction

endpackage

// File: rtl/proc_ctrl_decode.sv
// Combinational Moore output decoder: registered state plus IR operand fields -> datapath controls.
// Latency: 0 cycles (pure combinational). Backpressure: none. Jump outputs only with PROC_CTRL_JUMP_EN.
module proc_ctrl_decode
  import proc_pkg::*;
(
  input  state_t      state,
  input  logic [11:0] ir_fields,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_INIT:  ctrl.pc_clr = 1'b1;
      ST_FETCH: begin
        ctrl.ir_ld = 1'b1;
        ctrl.pc_up = 1'b1;
      end
      ST_LOAD_A: begin
        ctrl.d_addr = ir_fields[11:4];
        ctrl.rf_s   = 1'b1;
      end
      // Memory read data is only valid one cycle after the address, so write-back lands here.
      ST_LOAD_B: begin
        ctrl.d_addr    = ir_fields[11:4];
        ctrl.rf_s      = 1'b1;
        ctrl.rf_w_addr = ir_fields[3:0];
        ctrl.rf_w_en   = 1'b1;
      end
      ST_STORE: begin
        ctrl.d_addr     = ir_fields[7:0];
        ctrl.rf_ra_addr = ir_fields[11:8];
        ctrl.d_wr       = 1'b1;
      end
      ST_ADD, ST_SUB: begin
        ctrl.rf_ra_addr = ir_fields[11:8];
        ctrl.rf_rb_addr = ir_fields[7:4];
        ctrl.rf_w_addr  = ir_fields[3:0];
        ctrl.rf_w_en    = 1'b1;
        ctrl.alu_s0     = (state == ST_SUB) ? ALU_SUB : ALU_ADD;
      end
`ifdef PROC_CTRL_JUMP_EN
      ST_JUMP: begin
        ctrl.pc_addr = ir_fields[7:0];
        ctrl.pc_ld   = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/proc_controller.sv
// Moore FSM sequencing fetch/decode/execute for the 16-bit multicycle processor; JMP support via PROC_CTRL_JUMP_EN.
// Latency: 3 cycles per instruction, 4 for LOAD; HALT holds until Reset. Backpressure: none, free-running.
module proc_controller
  import proc_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [IR_W-1:0]   IR,
  output logic              PC_Clr,
  output logic              PC_Up,
  output logic              IR_Ld,
  output logic              PC_Ld,
  output logic [ADDR_W-1:0] PC_Addr,
  output logic [ADDR_W-1:0] D_Addr,
  output logic              D_Wr,
  output logic              RF_s,
  output logic [REG_AW-1:0] RF_W_Addr,
  output logic              RF_W_en,
  output logic [REG_AW-1:0] RF_Ra_Addr,
  output logic [REG_AW-1:0] RF_Rb_Addr,
  output logic [ALU_SW-1:0] ALU_s0,
  output logic [STATE_W-1:0] StateO
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode_of(IR))
          OP_LOAD:  state_d = ST_LOAD_A;
          OP_STORE: state_d = ST_STORE;
          OP_ADD:   state_d = ST_ADD;
          OP_SUB:   state_d = ST_SUB;
          OP_HALT:  state_d = ST_HALT;
`ifdef PROC_CTRL_JUMP_EN
          OP_JMP:   state_d = ST_JUMP;
`endif
          default:  state_d = ST_NOOP;
        endcase
      end
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_HALT:   state_d = ST_HALT;
      // Every execute state (and any stray code) returns to fetch.
      default:   state_d = ST_FETCH;
    endcase
  end

  proc_ctrl_decode u_decode (
    .state     (state_q),
    .ir_fields (IR[11:0]),
    .ctrl      (ctrl)
  );

  assign PC_Clr     = ctrl.pc_clr;
  assign PC_Up      = ctrl.pc_up;
  assign IR_Ld      = ctrl.ir_ld;
  assign PC_Ld      = ctrl.pc_ld;
  assign PC_Addr    = ctrl.pc_addr;
  assign D_Addr     = ctrl.d_addr;
  assign D_Wr       = ctrl.d_wr;
  assign RF_s       = ctrl.rf_s;
  assign RF_W_Addr  = ctrl.rf_w_addr;
  assign RF_W_en    = ctrl.rf_w_en;
  assign RF_Ra_Addr = ctrl.rf_ra_addr;
  assign RF_Rb_Addr = ctrl.rf_rb_addr;
  assign ALU_s0     = ctrl.alu_s0;
  assign StateO     = state_q;

endmodule

// File: tb/tb_proc_controller.sv
// Scoreboard bench for proc_controller: directed instruction sequence, hand-written expected outputs per cycle.
module tb_proc_controller;
  import proc_pkg::*;

  logic        Clk;
  logic        Reset;
  logic [15:0] IR;
  logic        PC_Clr, PC_Up, IR_Ld, PC_Ld, D_Wr, RF_s, RF_W_en;
  logic [7:0]  PC_Addr, D_Addr;
  logic [3:0]  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, StateO;
  logic [2:0]  ALU_s0;

  proc_controller dut (
    .Clk(Clk), .Reset(Reset), .IR(IR),
    .PC_Clr(PC_Clr), .PC_Up(PC_Up), .IR_Ld(IR_Ld), .PC_Ld(PC_Ld),
    .PC_Addr(PC_Addr), .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s),
    .RF_W_Addr(RF_W_Addr), .RF_W_en(RF_W_en), .RF_Ra_Addr(RF_Ra_Addr),
    .RF_Rb_Addr(RF_Rb_Addr), .ALU_s0(ALU_s0), .StateO(StateO)
  );

  typedef struct packed {
    logic [3:0] st;
    ctrl_t      c;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    tests  = 0;
  int    failed = 0;
  int    cyc    = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [3:0] st, input logic clr, input logic up,
                              input logic ild, input logic pld, input logic [7:0] paddr,
                              input logic [7:0] daddr, input logic dwr, input logic rfs,
                              input logic [3:0] wa, input logic wen, input logic [3:0] ra,
                              input logic [3:0] rb, input logic [2:0] alu);
    exp_t e;
    e.st = st;
    e.c  = '{pc_clr: clr, pc_up: up, ir_ld: ild, pc_ld: pld, pc_addr: paddr,
             d_addr: daddr, d_wr: dwr, rf_s: rfs, rf_w_addr: wa, rf_w_en: wen,
             rf_ra_addr: ra, rf_rb_addr: rb, alu_s0: alu};
    return e;
  endfunction

  function automatic exp_t e_init();   return mk(0, 1,0,0,0, 8'h00, 8'h00, 0,0, 4'h0,0, 4'h0,4'h0, 3'd0); endfunction
  function automatic exp_t e_fetch();  return mk(1, 0,1,1,0, 8'h00, 8'h00, 0,0, 4'h0,0, 4'h0,4'h0, 3'd0); endfunction
  function automatic exp_t e_decode(); return mk(2, 0,0,0,0, 8'h00, 8'h00, 0,0, 4'h0,0, 4'h0,4'h0, 3'd0); endfunction
  function automatic exp_t e_noop();   return mk(3, 0,0,0,0, 8'h00, 8'h00, 0,0, 4'h0,0, 4'h0,4'h0, 3'd0); endfunction
  function automatic exp_t e_halt();   return mk(9, 0,0,0,0, 8'h00, 8'h00, 0,0, 4'h0,0, 4'h0,4'h0, 3'd0); endfunction

  // One clock of stimulus: inputs already set, expected outputs for the state after this edge queued.
  task automatic step(input string nm, input exp_t e);
    @(posedge Clk);
    #1;
    sb_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // Monitor: the DUT presents a new output set every cycle; compare away from the edge.
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(negedge Clk);
      if (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        nm = nm_q.pop_front();
        a.st = StateO;
        a.c  = '{pc_clr: PC_Clr, pc_up: PC_Up, ir_ld: IR_Ld, pc_ld: PC_Ld, pc_addr: PC_Addr,
                 d_addr: D_Addr, d_wr: D_Wr, rf_s: RF_s, rf_w_addr: RF_W_Addr, rf_w_en: RF_W_en,
                 rf_ra_addr: RF_Ra_Addr, rf_rb_addr: RF_Rb_Addr, alu_s0: ALU_s0};
        tests++;
        if (a !== e) begin
          failed++;
          $display("FAIL cyc%0d %s: got state=%0d ctrl=%h, want state=%0d ctrl=%h",
                   cyc, nm, a.st, a.c, e.st, e.c);
        end
      end
    end
  end

  initial begin
    Reset = 1'b1;
    IR    = 16'h0000;
    step("reset0", e_init());
    step("reset1", e_init());
    Reset = 1'b0;
    step("fetch0", e_fetch());

    // LOAD R3 <- M[A5]
    IR = 16'h2A53;
    step("ld_dec", e_decode());
    step("ld_a", mk(4, 0,0,0,0, 8'h00, 8'hA5, 0,1, 4'h0,0, 4'h0,4'h0, 3'd0));
    step("ld_b", mk(5, 0,0,0,0, 8'h00, 8'hA5, 0,1, 4'h3,1, 4'h0,4'h0, 3'd0));
    step("ld_fetch", e_fetch());

    // ADD R7 = R1 + R2
    IR = 16'h3127;
    step("add_dec", e_decode());
    step("add_ex", mk(7, 0,0,0,0, 8'h00, 8'h00, 0,0, 4'h7,1, 4'h1,4'h2, 3'd1));
    step("add_fetch", e_fetch());

    // SUB R7 = R1 - R2
    IR = 16'h4127;
    step("sub_dec", e_decode());
    step("sub_ex", mk(8, 0,0,0,0, 8'h00, 8'h00, 0,0, 4'h7,1, 4'h1,4'h2, 3'd2));
    step("sub_fetch", e_fetch());

    // STORE M[C0] <- R4, write strobe for exactly one cycle
    IR = 16'h14C0;
    step("st_dec", e_decode());
    step("st_ex", mk(6, 0,0,0,0, 8'h00, 8'hC0, 1,0, 4'h0,0, 4'h4,4'h0, 3'd0));
    step("st_fetch", e_fetch());

    IR = 16'h6042;
    step("jmp_dec", e_decode());
`ifdef PROC_CTRL_JUMP_EN
    step("jmp_ex", mk(10, 0,0,0,1, 8'h42, 8'h00, 0,0, 4'h0,0, 4'h0,4'h0, 3'd0));
`else
    step("jmp_noop", e_noop());
`endif
    step("jmp_fetch", e_fetch());

    IR = 16'h0000;
    step("noop_dec", e_decode());
    step("noop_ex", e_noop());
    step("noop_fetch", e_fetch());

    // Undefined opcode behaves as NOOP
    IR = 16'hF123;
    step("undef_dec", e_decode());
    step("undef_ex", e_noop());
    step("undef_fetch", e_fetch());

    IR = 16'h5000;
    step("halt_dec", e_decode());
    for (int i = 0; i < 20; i++) step("halt_hold", e_halt());
    Reset = 1'b1;
    step("halt_reset", e_init());
    Reset = 1'b0;
    step("re_fetch", e_fetch());

    // Reset during Load_A must abort before write-back
    IR = 16'h2A53;
    step("abort_dec", e_decode());
    step("abort_ld_a", mk(4, 0,0,0,0, 8'h00, 8'hA5, 0,1, 4'h0,0, 4'h0,4'h0, 3'd0));
    Reset = 1'b1;
    step("abort_init", e_init());
    Reset = 1'b0;
    step("abort_fetch", e_fetch());
    step("abort_dec2", e_decode());
    step("abort_ld_a2", mk(4, 0,0,0,0, 8'h00, 8'hA5, 0,1, 4'h0,0, 4'h0,4'h0, 3'd0));

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge Clk);
    #1;
    tests++;
    if (sb_q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
